pat_gen_ctrl: RTL
=================

PAT_GEN_CTRL -- requirements
Module: pat_gen_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: core register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 14: core data width.
REQ-003 SHALL have parameter NUM_REGS, default 2: sub-registers programmed per pass, at least 1.
REQ-004 SHALL have parameter BASE_ADDR, default 0: address of sub-register 0.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 15: maximum WAIT_ACK cycles before error, at least 1.
REQ-006 SHALL define SUB_W as max(ADDR_WIDTH, DATA_WIDTH).
REQ-007 SHALL use one clock and a synchronous, active-low reset: wb_clk_i  in  1  sole clock; wb_rst_n_i  in  1  synchronous active-low reset.
REQ-008 SHALL have the following ports:
- start_i  in  1  start request, sampled in IDLE only.
- abort_i  in  1  abort request.
- rep_cnt_i  in  8  number of passes, latched at start.
- seed_i  in  SUB_W  first data word, latched at start.
- pg_ack_i  in  1  core acknowledge.
- bus_cyc_o  out  1  core cycle strobe.
- si_addr_o  out  ADDR_WIDTH  core address.
- cfg_pat_gen_o  out  1  pattern-generate configuration enable.
- ctl_pat_data_o  out  SUB_W  core data.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky timeout flag.
- pass_cnt_o  out  8  completed passes.

Function
REQ-009 SHALL implement the FSM states IDLE, ISSUE, WAIT_ACK, NEXT, DONE and ERR.
REQ-010 SHALL, in IDLE with start_i=1 and abort_i=0, clear err_o and pass_cnt_o and latch rep_cnt_i and seed_i.
REQ-011 SHALL, on such a start, go to ISSUE with reg_idx=0, or go to DONE if rep_cnt_i=0.
REQ-012 SHALL hold bus_cyc_o=1 and cfg_pat_gen_o=1 in ISSUE and WAIT_ACK only, and 0 elsewhere.
REQ-013 SHALL drive si_addr_o=BASE_ADDR+reg_idx (truncated to ADDR_WIDTH) and ctl_pat_data_o=data register while bus_cyc_o=1.
REQ-014 SHALL drive si_addr_o and ctl_pat_data_o to 0 while bus_cyc_o=0.
REQ-015 SHALL last exactly one cycle in ISSUE, then go to WAIT_ACK with the timeout counter cleared.
REQ-016 SHALL ignore pg_ack_i in every state except WAIT_ACK.
REQ-017 SHALL, in WAIT_ACK, go to NEXT on pg_ack_i=1; otherwise increment the timer and go to ERR when the timer reaches TIMEOUT_CYC.
REQ-018 SHALL let pg_ack_i win when ack and timeout-terminal occur in the same cycle.
REQ-019 SHALL, in NEXT, increment the data register modulo 2^SUB_W.
REQ-020 SHALL, in NEXT with reg_idx<NUM_REGS-1, increment reg_idx and go to ISSUE.
REQ-021 SHALL, in NEXT with reg_idx=NUM_REGS-1, clear reg_idx and increment pass_cnt_o.
REQ-022 SHALL, after that increment, go to DONE if the new pass_cnt_o equals the latched rep_cnt, else go to ISSUE.
REQ-023 SHALL assert done_o for exactly one cycle in DONE, then go to IDLE.
REQ-024 SHALL set err_o=1 in ERR, go to IDLE, and not assert done_o.
REQ-025 SHALL hold err_o at 1 until the next accepted start or reset.
REQ-026 SHALL, on abort_i=1 in any non-IDLE state, go to IDLE next cycle with bus_cyc_o=0 and no done_o pulse.
REQ-027 SHALL keep err_o and pass_cnt_o unchanged on abort.
REQ-028 SHALL ignore start_i while busy_o=1, and let abort_i win over start_i in IDLE.
REQ-029 SHALL meet this timing:
- bus_cyc_o rises in the cycle after an accepted start.
- A register access with same-cycle ack takes 3 cycles (ISSUE, WAIT_ACK, NEXT).

Reset
REQ-030 SHALL, with wb_rst_n_i=0 at a clock edge, enter IDLE and clear every output and internal register to 0.
REQ-031 SHALL give reset priority over abort_i and start_i.
REQ-032 SHALL, on reset mid-transaction, drop bus_cyc_o in the following cycle with no done_o pulse.

Structure
REQ-033 SHALL place the state enum, the SUB_W function and the 8-bit pass-counter width in a shared package pat_gen_ctrl_pkg.
REQ-034 SHALL instantiate one sub-module, pg_timeout_cnt: clear, enable and terminal-count output, parameterised by TIMEOUT_CYC.

Verification
REQ-035 SHALL cover: rep_cnt_i=1, seed_i=0x005, ack one cycle after ISSUE -> writes addr 0 data 0x005, then addr 1 data 0x006; pass_cnt_o=1; done_o pulses once.
REQ-036 SHALL cover: rep_cnt_i=3, NUM_REGS=2 -> 6 accesses, data 0x005..0x00A, done_o after pass_cnt_o=3.
REQ-037 SHALL cover: pg_ack_i never asserted -> err_o=1 after 15 WAIT_ACK cycles, bus_cyc_o=0, no done_o; next start clears err_o.
REQ-038 SHALL cover: seed_i=0x3FFF, SUB_W=14 -> second write data is 0x0000 (wrap).
REQ-039 SHALL cover: abort_i in WAIT_ACK of the second access -> IDLE next cycle, pass_cnt_o=0, no done_o; start_i while busy has no effect.
REQ-040 SHALL cover: wb_rst_n_i=0 during WAIT_ACK -> all outputs 0 next cycle; rep_cnt_i=0 -> done_o one cycle after start with no bus cycle.

Source files
------------

// File: rtl/pat_gen_ctrl_pkg.sv
// Shared types and helpers for the pattern-generator configuration sequencer.
package pat_gen_ctrl_pkg;

  localparam int PASS_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_NEXT     = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } pg_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pat_gen_ctrl_timeout.sv
// Acknowledge watchdog: counts enabled cycles and flags the last allowed one.
module pg_timeout_cnt #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  // term_o marks the TIMEOUT_CYC-th enabled cycle so the FSM leaves on that edge
  assign term_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !term_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pat_gen_ctrl.sv
// Writes NUM_REGS incrementing data words to the pattern-generator core per pass,
// repeating rep_cnt times, with ack timeout, abort and completion reporting.
module pat_gen_ctrl
  import pat_gen_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 14,
  parameter int NUM_REGS    = 2,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 15,
  localparam int SUB_W      = max_w(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [PASS_W-1:0]     rep_cnt_i,
  input  logic [SUB_W-1:0]      seed_i,
  input  logic                  pg_ack_i,
  output logic                  bus_cyc_o,
  output logic [ADDR_WIDTH-1:0] si_addr_o,
  output logic                  cfg_pat_gen_o,
  output logic [SUB_W-1:0]      ctl_pat_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [PASS_W-1:0]     pass_cnt_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  pg_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SUB_W-1:0]  data_q, data_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] rep_q, rep_d;
  logic              err_q, err_d;
  logic              tmo_clr, tmo_en, tmo_term;
  logic              abort_act;

  assign abort_act = abort_i && (state_q != S_IDLE);
  assign tmo_clr   = (state_q == S_ISSUE);
  assign tmo_en    = (state_q == S_WAIT_ACK) && !pg_ack_i && !abort_act;

  pg_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i  (wb_clk_i),
    .rst_n_i(wb_rst_n_i),
    .clr_i  (tmo_clr),
    .en_i   (tmo_en),
    .term_o (tmo_term)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      pass_q  <= '0;
      rep_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pass_q  <= pass_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    pass_d  = pass_q;
    rep_d   = rep_q;
    err_d   = err_q;
    // Abort freezes every datapath register; only the state returns to IDLE
    if (abort_act) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            err_d   = 1'b0;
            pass_d  = '0;
            rep_d   = rep_cnt_i;
            data_d  = seed_i;
            idx_d   = '0;
            state_d = (rep_cnt_i == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (pg_ack_i) begin
            state_d = S_NEXT;
          end else if (tmo_term) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_NEXT: begin
          data_d = data_q + 1'b1;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            idx_d   = '0;
            pass_d  = pass_q + 1'b1;
            state_d = ((pass_q + 1'b1) == rep_q) ? S_DONE : S_ISSUE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus_cyc_o      = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
  assign cfg_pat_gen_o  = bus_cyc_o;
  assign si_addr_o      = bus_cyc_o ? (BASE_A + ADDR_WIDTH'(idx_q)) : '0;
  assign ctl_pat_data_o = bus_cyc_o ? data_q : '0;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign err_o          = err_q;
  assign pass_cnt_o     = pass_q;

endmodule
